// File: rtl/clkmon_pkg.sv
// Shared types, default constants and the tolerance compare used by the
// clock period monitor.
package clkmon_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACQ,
        LOCKED
    } clkmon_state_e;

    localparam int DEF_EXP_PERIOD = 6;
    localparam int DEF_EXP_HIGH   = 3;
    localparam int DEF_TOL        = 0;
    localparam int DEF_LOCK_CNT   = 4;

    // True when |meas - expv| <= tol. Operands are 32-bit signed, which is
    // wider than any counter value plus one, so the difference cannot wrap.
    function automatic logic within_tol(input int meas, input int expv, input int tol);
        int signed diff;
        diff = meas - expv;
        return (diff <= tol) && (diff >= -tol);
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer for an asynchronous level plus a history flop that
// turns the synchronized level into a single-cycle rising-edge strobe.
module sync_edge_detect
    import clkmon_pkg::*;
(
    input  logic clk_in,
    input  logic reset,
    input  logic async_in,
    output logic rise,
    output logic lvl
);

    logic s1;
    logic s2;
    logic s3;

    // s1/s2 resolve metastability, s3 holds the previous synchronized level
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= async_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;
    assign lvl  = s2;

endmodule

// File: rtl/clock_period_monitor.sv
// Clock period monitor: measures each period of a slow divided clock mon_in
// in clk_in cycles, compares it against EXP_PERIOD +/- TOL and tracks lock
// through an IDLE/ACQ/LOCKED state machine. Stalls are flagged when no edge
// arrives within 2*EXP_PERIOD+TOL cycles.
// Optional feature: define CLKMON_DUTY_CHECK_EN to also measure the high
// phase against EXP_HIGH +/- TOL; a duty error then counts as a bad period.
module clock_period_monitor
    import clkmon_pkg::*;
#(
    parameter int CNT_W      = 8,
    parameter int EXP_PERIOD = DEF_EXP_PERIOD,
    parameter int EXP_HIGH   = DEF_EXP_HIGH,
    parameter int TOL        = DEF_TOL,
    parameter int LOCK_CNT   = DEF_LOCK_CNT
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             mon_in,
    output logic [CNT_W-1:0] period_o,
    output logic             period_valid,
    output logic             locked,
    output logic             period_err,
    output logic             stall_err,
    output logic             duty_err
);

    localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(2 * EXP_PERIOD + TOL);
    localparam int               GOOD_W    = $clog2(LOCK_CNT + 1);
    localparam logic [GOOD_W-1:0] LOCK_V   = GOOD_W'(LOCK_CNT);

    // Saturating increment so a stuck clock cannot wrap the counters.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    // Clamp the one-bit-wider measurement onto the output width.
    function automatic logic [CNT_W-1:0] sat_to_cnt(input logic [CNT_W:0] v);
        return v[CNT_W] ? '1 : v[CNT_W-1:0];
    endfunction

    logic              rise;
    logic              s2_lvl;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W:0]    meas;
    logic              at_limit;
    logic              timeout;
    logic              period_bad;
    logic              duty_bad;
    logic              meas_good;
    clkmon_state_e     state;
    logic [GOOD_W-1:0] good;
    logic [GOOD_W-1:0] good_inc;

    sync_edge_detect u_sync (
        .clk_in   (clk_in),
        .reset    (reset),
        .async_in (mon_in),
        .rise     (rise),
        .lvl      (s2_lvl)
    );

    // The rise cycle itself is part of the period, hence cnt + 1.
    assign meas     = {1'b0, cnt} + {{CNT_W{1'b0}}, 1'b1};
    assign at_limit = (cnt == TIMEOUT_V);
    assign timeout  = at_limit & ~rise;
    // A rise landing exactly on the timeout count is measured but always bad.
    assign period_bad = ~within_tol(int'(meas), EXP_PERIOD, TOL) | at_limit;
    assign meas_good  = ~period_bad & ~duty_bad;
    assign good_inc   = good + GOOD_W'(1);

    // Period counter: restarts on every edge and on a stall outside IDLE
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (rise || (timeout && (state != IDLE))) begin
            cnt <= '0;
        end else begin
            cnt <= sat_inc(cnt);
        end
    end

`ifdef CLKMON_DUTY_CHECK_EN
    logic [CNT_W-1:0] hcnt;

    // High-phase counter: the rise cycle counts as the first high cycle
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            hcnt <= '0;
        end else if (rise) begin
            hcnt <= CNT_W'(1);
        end else if (s2_lvl) begin
            hcnt <= sat_inc(hcnt);
        end
    end

    assign duty_bad = ~within_tol(int'(hcnt), EXP_HIGH, TOL);
`else
    localparam int unused_exp_high = EXP_HIGH;
    logic unused_lvl;

    assign unused_lvl = s2_lvl;
    assign duty_bad   = 1'b0;
`endif

    // Lock state machine with registered measurement, lock and error outputs
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            good         <= '0;
            period_o     <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            period_err   <= 1'b0;
            stall_err    <= 1'b0;
            duty_err     <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            period_err   <= 1'b0;
            stall_err    <= 1'b0;
            duty_err     <= 1'b0;
            unique case (state)
                IDLE: begin
                    // first edge only starts the measurement window
                    if (rise) begin
                        state <= ACQ;
                        good  <= '0;
                    end
                end
                ACQ: begin
                    if (rise) begin
                        period_o     <= sat_to_cnt(meas);
                        period_valid <= 1'b1;
                        period_err   <= period_bad;
                        duty_err     <= duty_bad & ~period_bad;
                        if (meas_good) begin
                            good <= good_inc;
                            if (good_inc == LOCK_V) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end
                        end else begin
                            good <= '0;
                        end
                    end else if (timeout) begin
                        stall_err <= 1'b1;
                        state     <= IDLE;
                        good      <= '0;
                    end
                end
                LOCKED: begin
                    if (rise) begin
                        period_o     <= sat_to_cnt(meas);
                        period_valid <= 1'b1;
                        period_err   <= period_bad;
                        duty_err     <= duty_bad & ~period_bad;
                        if (!meas_good) begin
                            state  <= ACQ;
                            locked <= 1'b0;
                            good   <= '0;
                        end
                    end else if (timeout) begin
                        stall_err <= 1'b1;
                        locked    <= 1'b0;
                        state     <= IDLE;
                        good      <= '0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    locked <= 1'b0;
                    good   <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/clock_period_monitor.md
# clock_period_monitor

Measures the period of a slow divided clock, such as the divide-by-N outputs produced in this design, against an expected value and reports lock. It runs on the fast source clock `clk_in` and samples the divided clock `mon_in` as asynchronous data. It provides a per-period measurement, a lock flag, and error pulses for frequency deviation and stalls. It sits beside each clock divider as its checker and consumer.

## Interface
- `CNT_W`, default 8: width of the period/high counters.
- `EXP_PERIOD`, default 6: expected `mon_in` period, in `clk_in` cycles.
- `EXP_HIGH`, default 3: expected high-phase length, in `clk_in` cycles.
- `TOL`, default 0: allowed ± deviation, in cycles, for period and high phase.
- `LOCK_CNT`, default 4: number of consecutive good periods required to lock.
- `clk_in`  input  1  the only clock; all logic is clocked on its rising edge.
- `reset`  input  1  asynchronous, active-high; clears all state.
- `mon_in`  input  1  divided clock under test; asynchronous to `clk_in`.
- `period_o`  output  CNT_W  last measured period, in cycles.
- `period_valid`  output  1  one-cycle pulse when `period_o` updates.
- `locked`  output  1  level; high while in state LOCKED.
- `period_err`  output  1  one-cycle pulse when a measured period is out of tolerance.
- `stall_err`  output  1  one-cycle pulse when a timeout occurs with no rising edge.
- `duty_err`  output  1  one-cycle pulse when the high phase is out of tolerance (see Configuration).

All outputs reset to 0.

## Operation
- **Input path:** 2-flop synchronizer `s1` → `s2`, followed by history flop `s3`. `rise = s2 & ~s3`.
- **Period counter `cnt`:**
  - Reset value 0.
  - On a cycle without `rise`: `cnt <= cnt + 1`, saturating at 2^CNT_W−1.
  - On a cycle with `rise`: measured period is `cnt + 1`, and `cnt <= 0`.
- **High counter `hcnt`:**
  - Increments, saturating, on each cycle with `s2 == 1` and no `rise`.
  - On `rise`: captured value is `hcnt`; `hcnt` then loads 1.
- **Good period:** |meas − EXP_PERIOD| ≤ TOL. Use `CNT_W+1`-bit signed compare; no wrap.
- **Timeout:** fires when `cnt == 2*EXP_PERIOD + TOL` without a `rise`.
- **State machine:**
  - **IDLE:** entered on reset and on timeout.
    - On the first `rise`: go to ACQ with `good = 0`.
    - No measurement is published for this first edge.
  - **ACQ:** on each `rise`, publish `period_o` and pulse `period_valid`.
    - Good period: `good++`. When `good == LOCK_CNT`, go to LOCKED.
    - Bad period: pulse `period_err` and set `good = 0`.
  - **LOCKED:** on each `rise`, publish the measurement.
    - Bad period: pulse `period_err`, go to ACQ with `good = 0`.
  - **Timeout in ACQ or LOCKED:** pulse `stall_err`, go to IDLE, clear `cnt` and `good`.
  - **Timeout in IDLE:** no `stall_err` pulse. `cnt` simply saturates.
- **Simultaneous `rise` and timeout count:** `rise` wins. The period is measured normally and is judged bad.
- **Reset mid-measurement:** discards everything. The first edge after reset is never measured.

## Timing
- A `mon_in` rising edge produces `rise` two `clk_in` edges later.
- `period_o`, `period_valid` and the error pulses are registered at the third `clk_in` edge after `mon_in` rises. Fixed latency: 3 cycles.
- `locked` rises in the same cycle as the `period_valid` of the LOCK_CNT-th good period.
- `locked` falls in the same cycle as the `period_err` or `stall_err` pulse.
- Error pulses last exactly one cycle and never overlap.
- `mon_in` pulses shorter than 2 `clk_in` cycles may be missed. This is allowed, and the missed edge is reported as a bad period.

## Configuration
- **`CLKMON_DUTY_CHECK_EN` defined:**
  - `hcnt` is built.
  - On each measured `rise`, |hcnt − EXP_HIGH| > TOL pulses `duty_err`.
  - A duty error counts as a bad period for the lock state machine.
- **`CLKMON_DUTY_CHECK_EN` undefined:**
  - `hcnt` is not built.
  - `duty_err` is tied to 0.
  - Lock depends on period only.

## Structure
- Shared package `clkmon_pkg` holds:
  - the state enum `{IDLE, ACQ, LOCKED}`;
  - the default constants for EXP_PERIOD, EXP_HIGH, TOL and LOCK_CNT;
  - the tolerance-compare function.
- One sub-module, `sync_edge_detect`: 2-flop synchronizer plus history flop, with outputs `rise` and `lvl`. It uses the same `clk_in`/`reset`.

## Test plan
- **Nominal:** `mon_in` toggles every 3 `clk_in` cycles (period 6).
  - `period_valid` appears every 6 cycles with `period_o = 6`.
  - `locked = 1` at the 4th `period_valid`, i.e. the 5th `mon_in` rise.
- **Deviation:** after lock, insert one period of 7 with TOL = 0.
  - One `period_err` pulse, `locked` falls, `period_o = 7`.
  - Relock after 4 more periods of 6.
- **Tolerance:** TOL = 1, periods alternating 5, 6, 7.
  - No `period_err`; lock at the 4th measurement.
- **Stall:** while locked, hold `mon_in` low.
  - One `stall_err` pulse 13 cycles after the last `rise`, then state IDLE.
  - The next rise produces no `period_valid`.
- **Reset:** assert `reset` for 1 cycle mid-period while locked.
  - All outputs are 0 immediately.
  - Lock returns 5 rises after release.
- **Duty** (macro on): high 2 / low 4 cycles.
  - `duty_err` pulses on every measurement with `period_o = 6`, and lock is never reached.
  - With the macro off: `duty_err` stays 0 and lock is reached.
